recip_period_counter: RTL and testbench

Parametrised reciprocal frequency counter. It measures the width of each high phase of an asynchronous sample_gate in ref_clk cycles. Each result is published as a registered count with a one-cycle valid strobe, plus overflow and runt status flags. It sits between the gate generator and the frequency-computation logic, and adds synchronisation, arming, saturation and optional averaging.

---
 rtl/recip_period_counter.sv | 209 ++++++++++++++++++++
 tb/tb_recip_period_counter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/recip_period_counter.sv
// Reciprocal frequency counter: counts ref_clk cycles of each synchronised high phase of sample_gate.
// Optional batch averaging of 2^AVG_LOG2 measurements is enabled by defining RECIP_AVG_EN.
module recip_period_counter #(
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int MIN_COUNT   = 4,
  parameter int AVG_LOG2    = 2
) (
  input  logic             ref_clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             sample_gate,
  output logic [CNT_W-1:0] recip_counter,
  output logic             recip_valid,
  output logic             recip_overflow,
  output logic             recip_runt,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_WAIT  = 2'd2,
    ST_COUNT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_RUNT = CNT_W'(MIN_COUNT);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   g_s, g_d_q, g_rise_s, g_fall_s;
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   ovf_q, ovf_d;
  logic                   pub_q, pub_d;
  logic                   runt_s;
  logic [CNT_W-1:0]       out_cnt_q, out_cnt_d;
  logic                   out_valid_q, out_valid_d;
  logic                   out_ovf_q, out_ovf_d;
  logic                   out_runt_q, out_runt_d;
  logic                   busy_q;

  assign g_s      = sync_q[SYNC_STAGES-1];
  assign g_rise_s = g_s & ~g_d_q;
  assign g_fall_s = ~g_s & g_d_q;
  assign runt_s   = (cnt_q < CNT_RUNT);

  // Gate synchroniser and one-cycle delayed copy for edge detection
  always_ff @(posedge ref_clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      g_d_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sample_gate};
      g_d_q  <= g_s;
    end
  end

  // Measurement FSM state, counter and publish request registers
  always_ff @(posedge ref_clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      pub_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      pub_q   <= pub_d;
      busy_q  <= (state_d == ST_COUNT);
    end
  end

  // Next-state logic; dropping enable aborts from any state without publishing
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    pub_d   = 1'b0;
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_ARM;
        // A gate already high at arming time is skipped until it goes low
        ST_ARM: begin
          if (!g_s) state_d = ST_WAIT;
          else      state_d = ST_ARM;
        end
        ST_WAIT: begin
          if (g_rise_s) begin
            state_d = ST_COUNT;
            cnt_d   = CNT_ONE;
            ovf_d   = 1'b0;
          end else begin
            state_d = ST_WAIT;
          end
        end
        ST_COUNT: begin
          if (g_fall_s) begin
            state_d = ST_WAIT;
            pub_d   = 1'b1;
          end else if (cnt_q == CNT_MAX) begin
            ovf_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

`ifdef RECIP_AVG_EN
  localparam logic [AVG_LOG2-1:0] IDX_LAST = {AVG_LOG2{1'b1}};
  localparam logic [AVG_LOG2-1:0] IDX_ONE  = AVG_LOG2'(1);

  logic [CNT_W+AVG_LOG2-1:0] acc_q, acc_d, sum_s;
  logic [AVG_LOG2-1:0]       idx_q, idx_d;
  logic                      aovf_q, aovf_d, arunt_q, arunt_d;

  assign sum_s = acc_q + {{AVG_LOG2{1'b0}}, cnt_q};

  // Batch accumulator, batch index and sticky batch flags
  always_ff @(posedge ref_clk or negedge reset) begin
    if (!reset) begin
      acc_q   <= '0;
      idx_q   <= '0;
      aovf_q  <= 1'b0;
      arunt_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      aovf_q  <= aovf_d;
      arunt_q <= arunt_d;
    end
  end
`endif

  // Result publication; outputs hold between strobes
  always_comb begin
    out_cnt_d   = out_cnt_q;
    out_ovf_d   = out_ovf_q;
    out_runt_d  = out_runt_q;
    out_valid_d = 1'b0;
`ifdef RECIP_AVG_EN
    acc_d   = acc_q;
    idx_d   = idx_q;
    aovf_d  = aovf_q;
    arunt_d = arunt_q;
    if (!enable) begin
      acc_d   = '0;
      idx_d   = '0;
      aovf_d  = 1'b0;
      arunt_d = 1'b0;
    end else if (pub_q && (idx_q == IDX_LAST)) begin
      out_valid_d = 1'b1;
      out_cnt_d   = sum_s[CNT_W+AVG_LOG2-1:AVG_LOG2];
      out_ovf_d   = aovf_q | ovf_q;
      out_runt_d  = arunt_q | runt_s;
      acc_d       = '0;
      idx_d       = '0;
      aovf_d      = 1'b0;
      arunt_d     = 1'b0;
    end else if (pub_q) begin
      acc_d   = sum_s;
      idx_d   = idx_q + IDX_ONE;
      aovf_d  = aovf_q | ovf_q;
      arunt_d = arunt_q | runt_s;
    end else begin
      acc_d = acc_q;
    end
`else
    if (pub_q) begin
      out_valid_d = 1'b1;
      out_cnt_d   = cnt_q;
      out_ovf_d   = ovf_q;
      out_runt_d  = runt_s;
    end else begin
      out_valid_d = 1'b0;
    end
`endif
  end

  // Registered result outputs
  always_ff @(posedge ref_clk or negedge reset) begin
    if (!reset) begin
      out_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_ovf_q   <= 1'b0;
      out_runt_q  <= 1'b0;
    end else begin
      out_cnt_q   <= out_cnt_d;
      out_valid_q <= out_valid_d;
      out_ovf_q   <= out_ovf_d;
      out_runt_q  <= out_runt_d;
    end
  end

  assign recip_counter  = out_cnt_q;
  assign recip_valid    = out_valid_q;
  assign recip_overflow = out_ovf_q;
  assign recip_runt     = out_runt_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_recip_period_counter.sv
// Directed bench for recip_period_counter: a 32-bit and an 8-bit instance share the same stimulus.
// Inputs change on the falling clock edge, so every count is exact (no sampling jitter).
module tb_recip_period_counter;

  logic        clk, rst_n, enable, gate;
  logic [31:0] rc;
  logic [7:0]  rc8;
  logic        rv, rov, rrunt, rbusy;
  logic        rv8, rov8, rrunt8, rbusy8;
  int          chk_n, pass_n, fail_n, v_n, v8_n, lat;

  recip_period_counter dut (
    .ref_clk(clk), .reset(rst_n), .enable(enable), .sample_gate(gate),
    .recip_counter(rc), .recip_valid(rv), .recip_overflow(rov),
    .recip_runt(rrunt), .busy(rbusy)
  );

  recip_period_counter #(.CNT_W(8)) dut8 (
    .ref_clk(clk), .reset(rst_n), .enable(enable), .sample_gate(gate),
    .recip_counter(rc8), .recip_valid(rv8), .recip_overflow(rov8),
    .recip_runt(rrunt8), .busy(rbusy8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count valid strobes, sampled 2 ns after each rising edge
  always @(posedge clk) begin
    #2;
    if (rv)  v_n++;
    if (rv8) v8_n++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_n++;
    assert (obs === exp) pass_n++;
    else begin
      fail_n++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse(input int n, input int gap);
    gate = 1'b1;
    repeat (n) @(negedge clk);
    gate = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  initial begin
    chk_n = 0; pass_n = 0; fail_n = 0; v_n = 0; v8_n = 0; lat = 0;
    rst_n = 1'b0; enable = 1'b1; gate = 1'b0;

    // Reset held with enable high and gate toggling
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      gate = ~gate;
    end
    @(negedge clk);
    check("rst_counter",  rc,    64'd0);
    check("rst_valid",    rv,    64'd0);
    check("rst_overflow", rov,   64'd0);
    check("rst_runt",     rrunt, 64'd0);
    check("rst_busy",     rbusy, 64'd0);
    check("rst_nvalid",   v_n,   64'd0);

    enable = 1'b0; gate = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pulse(6, 4);
    end
    check("idle_busy",   rbusy, 64'd0);
    check("idle_nvalid", v_n,   64'd0);

    enable = 1'b1;
    repeat (5) @(negedge clk);

`ifdef RECIP_AVG_EN
    pulse(100, 10);
    pulse(102, 10);
    pulse(98, 10);
    check("avg_no_early_valid", v_n, 64'd0);
    pulse(104, 10);
    check("avg_nvalid",   v_n,   64'd1);
    check("avg_counter",  rc,    64'd101);
    check("avg_overflow", rov,   64'd0);
    check("avg_runt",     rrunt, 64'd0);
    check("avg8_counter", rc8,   64'd101);
    check("avg8_nvalid",  v8_n,  64'd1);
`else
    // 1000-cycle gate: exact count, and saturation on the 8-bit instance
    gate = 1'b1;
    repeat (500) @(negedge clk);
    check("busy_mid_gate", rbusy, 64'd1);
    repeat (500) @(negedge clk);
    gate = 1'b0;
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      if (rv && lat == 0) lat = j;
    end
    check("latency",        lat,   64'd4);
    check("basic_counter",  rc,    64'd1000);
    check("basic_overflow", rov,   64'd0);
    check("basic_runt",     rrunt, 64'd0);
    check("basic_nvalid",   v_n,   64'd1);
    check("busy_after",     rbusy, 64'd0);
    check("ovf8_counter",   rc8,   64'd255);
    check("ovf8_flag",      rov8,  64'd1);

    // Overflow flag clears for the next measurement
    pulse(100, 10);
    check("g100_counter",  rc,   64'd100);
    check("ovf8_next_cnt", rc8,  64'd100);
    check("ovf8_next_flg", rov8, 64'd0);
    check("g100_nvalid",   v_n,  64'd2);

    // Gate already high when enable rises is not measured
    enable = 1'b0;
    repeat (3) @(negedge clk);
    gate = 1'b1;
    repeat (5) @(negedge clk);
    enable = 1'b1;
    repeat (10) @(negedge clk);
    check("arm_busy", rbusy, 64'd0);
    repeat (485) @(negedge clk);
    gate = 1'b0;
    repeat (10) @(negedge clk);
    pulse(200, 10);
    check("prehigh_nvalid",  v_n, 64'd3);
    check("prehigh_counter", rc,  64'd200);

    // Runt boundary around MIN_COUNT = 4
    pulse(2, 10);
    check("runt2_counter", rc,    64'd2);
    check("runt2_flag",    rrunt, 64'd1);
    pulse(4, 10);
    check("runt4_counter", rc,    64'd4);
    check("runt4_flag",    rrunt, 64'd0);
    check("runt_nvalid",   v_n,   64'd5);

    // Abort: enable drops halfway through a 100-cycle gate
    gate = 1'b1;
    repeat (50) @(negedge clk);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_busy", rbusy, 64'd0);
    repeat (48) @(negedge clk);
    gate = 1'b0;
    repeat (10) @(negedge clk);
    check("abort_nvalid",  v_n, 64'd5);
    check("abort_counter", rc,  64'd4);

    // Back-to-back gates separated by a single low cycle
    enable = 1'b1;
    repeat (5) @(negedge clk);
    gate = 1'b1;
    repeat (5) @(negedge clk);
    gate = 1'b0;
    @(negedge clk);
    pulse(6, 10);
    check("b2b_nvalid",  v_n,   64'd7);
    check("b2b_counter", rc,    64'd6);
    check("b2b_runt",    rrunt, 64'd0);
`endif

    $display("%0d/%0d checks passed", pass_n, chk_n);
    $finish;
  end

endmodule
